// File: rtl/apb_rr_arbiter.sv
// Round-robin arbiter/sequencer in front of a single APB master.
// Latches the winner's command, pulses o_transfer once, and returns done/rdata to the owner.
module apb_rr_arbiter #(
    parameter int WIDTH   = 8,
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                     i_PCLK,
    input  logic                     i_PRESET,
    input  logic [NUM_REQ-1:0]       i_req_valid,
    input  logic [NUM_REQ-1:0]       i_req_write,
    input  logic [NUM_REQ*WIDTH-1:0] i_req_addr,
    input  logic [NUM_REQ*WIDTH-1:0] i_req_wdata,
    input  logic                     i_PENABLE,
    input  logic                     i_PREADY,
    input  logic [WIDTH-1:0]         i_apb_read_data,
    input  logic                     i_err_clr,
    output logic                     o_transfer,
    output logic                     o_READ_WRITE,
    output logic [WIDTH-1:0]         o_apb_write_paddr,
    output logic [WIDTH-1:0]         o_apb_write_data,
    output logic [WIDTH-1:0]         o_apb_read_paddr,
    output logic [NUM_REQ-1:0]       o_grant,
    output logic [NUM_REQ-1:0]       o_req_done,
    output logic [WIDTH-1:0]         o_req_rdata,
    output logic                     o_timeout_err,
    output logic [1:0]               o_dbg_state
);

    localparam int PW = $clog2(NUM_REQ);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_ISSUE    = 2'd1,
        S_WAIT     = 2'd2,
        S_COMPLETE = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_next;

    logic [PW-1:0]       r_ptr;
    logic [NUM_REQ-1:0]  r_grant;
    logic [NUM_REQ-1:0]  r_done;
    logic [WIDTH-1:0]    r_rdata;
    logic                r_transfer;
    logic                r_rw;
    logic [WIDTH-1:0]    r_wr_paddr;
    logic [WIDTH-1:0]    r_wr_data;
    logic [WIDTH-1:0]    r_rd_paddr;
    logic [CW-1:0]       r_cnt;
    logic                r_err;

    logic                w_found;
    logic [PW-1:0]       w_idx;
    logic [PW-1:0]       w_cand;
    logic [PW-1:0]       w_ptr_next;
    int                  w_k;
    logic                w_access_done;
    logic                w_sel_write;
    logic [WIDTH-1:0]    w_sel_addr;
    logic [WIDTH-1:0]    w_sel_wdata;

    // Scan downward so the last hit (closest to the pointer) wins.
    always_comb begin
        w_found = 1'b0;
        w_idx   = '0;
        w_k     = 0;
        w_cand  = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            w_k = int'(r_ptr) + i;
            if (w_k >= NUM_REQ) begin
                w_k = w_k - NUM_REQ;
            end
            w_cand = PW'(w_k);
            if (i_req_valid[w_cand]) begin
                w_found = 1'b1;
                w_idx   = w_cand;
            end
        end
    end

    assign w_ptr_next    = (w_idx == PW'(NUM_REQ - 1)) ? '0 : w_idx + 1'b1;
    assign w_access_done = i_PENABLE && i_PREADY;
    assign w_sel_write   = i_req_write[w_idx];
    assign w_sel_addr    = i_req_addr[w_idx*WIDTH +: WIDTH];
    assign w_sel_wdata   = i_req_wdata[w_idx*WIDTH +: WIDTH];

    always_ff @(posedge i_PCLK or posedge i_PRESET) begin
        if (i_PRESET) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_state_next = S_WAIT;
            end
            S_WAIT: begin
                if (w_access_done) begin
                    w_state_next = S_COMPLETE;
                end
            end
            S_COMPLETE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Command/holding registers double as the outputs so they cannot glitch mid-access.
    always_ff @(posedge i_PCLK or posedge i_PRESET) begin
        if (i_PRESET) begin
            r_ptr      <= '0;
            r_grant    <= '0;
            r_done     <= '0;
            r_rdata    <= '0;
            r_transfer <= 1'b0;
            r_rw       <= 1'b0;
            r_wr_paddr <= '0;
            r_wr_data  <= '0;
            r_rd_paddr <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_grant    <= NUM_REQ'(1) << w_idx;
                        r_ptr      <= w_ptr_next;
                        r_transfer <= 1'b1;
                        r_rdata    <= '0;
                        r_rw       <= w_sel_write;
                        r_wr_paddr <= w_sel_write ? w_sel_addr  : '0;
                        r_wr_data  <= w_sel_write ? w_sel_wdata : '0;
                        r_rd_paddr <= w_sel_write ? '0 : w_sel_addr;
                    end
                end
                S_ISSUE: begin
                    r_transfer <= 1'b0;
                end
                S_WAIT: begin
                    if (w_access_done) begin
                        r_done <= r_grant;
                        if (!r_rw) begin
                            r_rdata <= i_apb_read_data;
                        end
                    end
                end
                S_COMPLETE: begin
                    r_done     <= '0;
                    r_grant    <= '0;
                    r_rdata    <= '0;
                    r_rw       <= 1'b0;
                    r_wr_paddr <= '0;
                    r_wr_data  <= '0;
                    r_rd_paddr <= '0;
                end
                default: begin
                    r_transfer <= 1'b0;
                end
            endcase
        end
    end

    // Watchdog saturates at TIMEOUT so a held i_err_clr is not overridden repeatedly.
    always_ff @(posedge i_PCLK or posedge i_PRESET) begin
        if (i_PRESET) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            if (r_state == S_WAIT) begin
                if (r_cnt != CW'(TIMEOUT)) begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                r_cnt <= '0;
            end
            if ((r_state == S_WAIT) && (r_cnt == CW'(TIMEOUT - 1))) begin
                r_err <= 1'b1;
            end else if (i_err_clr) begin
                r_err <= 1'b0;
            end
        end
    end

    assign o_transfer        = r_transfer;
    assign o_READ_WRITE      = r_rw;
    assign o_apb_write_paddr = r_wr_paddr;
    assign o_apb_write_data  = r_wr_data;
    assign o_apb_read_paddr  = r_rd_paddr;
    assign o_grant           = r_grant;
    assign o_req_done        = r_done;
    assign o_req_rdata       = r_rdata;
    assign o_timeout_err     = r_err;
    assign o_dbg_state       = r_state;

endmodule

// File: tb/tb_apb_rr_arbiter.sv
// Directed testbench for apb_rr_arbiter: each scenario task drives a bus sequence
// and compares outputs against hand-computed values one cycle at a time.
module tb_apb_rr_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [3:0]  req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        penable;
    logic        pready;
    logic [7:0]  rdata_in;
    logic        err_clr;

    logic        o_transfer;
    logic        o_rw;
    logic [7:0]  o_wr_paddr;
    logic [7:0]  o_wr_data;
    logic [7:0]  o_rd_paddr;
    logic [3:0]  o_grant;
    logic [3:0]  o_done;
    logic [7:0]  o_rdata;
    logic        o_err;
    logic [1:0]  o_state;

    int n_checks = 0;
    int n_errors = 0;

    apb_rr_arbiter #(.WIDTH(8), .NUM_REQ(4), .TIMEOUT(16)) dut (
        .i_PCLK            (clk),
        .i_PRESET          (rst),
        .i_req_valid       (req_valid),
        .i_req_write       (req_write),
        .i_req_addr        (req_addr),
        .i_req_wdata       (req_wdata),
        .i_PENABLE         (penable),
        .i_PREADY          (pready),
        .i_apb_read_data   (rdata_in),
        .i_err_clr         (err_clr),
        .o_transfer        (o_transfer),
        .o_READ_WRITE      (o_rw),
        .o_apb_write_paddr (o_wr_paddr),
        .o_apb_write_data  (o_wr_data),
        .o_apb_read_paddr  (o_rd_paddr),
        .o_grant           (o_grant),
        .o_req_done        (o_done),
        .o_req_rdata       (o_rdata),
        .o_timeout_err     (o_err),
        .o_dbg_state       (o_state)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: sim time limit reached, required finish");
        $fatal(1);
    end

    function automatic logic [42:0] all_outs();
        return {o_transfer, o_rw, o_wr_paddr, o_wr_data, o_rd_paddr,
                o_grant, o_done, o_rdata, o_err};
    endfunction

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int k, input logic wr, input logic [7:0] addr,
                           input logic [7:0] wdata);
        req_valid[k]         = 1'b1;
        req_write[k]         = wr;
        req_addr[k*8 +: 8]   = addr;
        req_wdata[k*8 +: 8]  = wdata;
    endtask

    task automatic wait_transfer(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 8; n++) begin
            tick();
            if (o_transfer === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Called in the ISSUE cycle; returns in the cycle where done is expected.
    task automatic apb_slave(input int waits, input logic [7:0] rd);
        tick();
        tick();
        penable  = 1'b1;
        pready   = (waits == 0);
        rdata_in = rd;
        for (int n = 0; n < waits; n++) begin
            tick();
            pready = (n == waits - 1);
        end
        tick();
        penable = 1'b0;
        pready  = 1'b0;
    endtask

    // Scenario tasks
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        n_checks++;
        if (all_outs() !== 43'd0) begin
            n_errors++;
            $display("FAIL reset_outs: got %h want 0", all_outs());
        end
        rst = 1'b0;
        tick();
        tick();
        n_checks++;
        if (all_outs() !== 43'd0 || o_state !== 2'd0) begin
            n_errors++;
            $display("FAIL idle_after_reset: got outs=%h state=%0d want 0/0", all_outs(), o_state);
        end
    endtask

    task automatic test_rr_fairness();
        bit ok;
        int exp_k;
        for (int k = 0; k < 4; k++) set_req(k, 1'b0, 8'h40 + 8'(k), 8'h00);
        for (int i = 0; i < 5; i++) begin
            exp_k = i % 4;
            wait_transfer(ok);
            n_checks++;
            if (!ok) begin
                n_errors++;
                $display("FAIL rr_transfer_%0d: got no transfer want transfer", i);
            end
            n_checks++;
            if (o_grant !== 4'(1 << exp_k)) begin
                n_errors++;
                $display("FAIL rr_grant_%0d: got %b want %b", i, o_grant, 4'(1 << exp_k));
            end
            n_checks++;
            if (o_rd_paddr !== 8'h40 + 8'(exp_k)) begin
                n_errors++;
                $display("FAIL rr_paddr_%0d: got %h want %h", i, o_rd_paddr, 8'h40 + 8'(exp_k));
            end
            apb_slave(0, 8'h80 + 8'(i));
            n_checks++;
            if (o_done !== 4'(1 << exp_k) || o_rdata !== 8'h80 + 8'(i)) begin
                n_errors++;
                $display("FAIL rr_done_%0d: got done=%b rdata=%h want %b/%h",
                         i, o_done, o_rdata, 4'(1 << exp_k), 8'h80 + 8'(i));
            end
        end
        req_valid = 4'b0000;
        tick();
    endtask

    task automatic test_single_write();
        set_req(1, 1'b1, 8'h3C, 8'hA5);
        tick();
        n_checks++;
        if ({o_transfer, o_grant, o_rw, o_wr_paddr, o_wr_data, o_rd_paddr}
            !== {1'b1, 4'b0010, 1'b1, 8'h3C, 8'hA5, 8'h00}) begin
            n_errors++;
            $display("FAIL wr_issue: got t=%b g=%b rw=%b wa=%h wd=%h ra=%h want 1/0010/1/3c/a5/00",
                     o_transfer, o_grant, o_rw, o_wr_paddr, o_wr_data, o_rd_paddr);
        end
        set_req(1, 1'b0, 8'h77, 8'h11);
        tick();
        n_checks++;
        if (o_transfer !== 1'b0 || o_state !== 2'd2) begin
            n_errors++;
            $display("FAIL wr_wait: got t=%b state=%0d want 0/2", o_transfer, o_state);
        end
        tick();
        penable  = 1'b1;
        pready   = 1'b1;
        rdata_in = 8'hFF;
        tick();
        n_checks++;
        if ({o_done, o_grant, o_rdata, o_rw, o_wr_paddr, o_wr_data}
            !== {4'b0010, 4'b0010, 8'h00, 1'b1, 8'h3C, 8'hA5}) begin
            n_errors++;
            $display("FAIL wr_done: got d=%b g=%b rd=%h rw=%b wa=%h wd=%h want 0010/0010/00/1/3c/a5",
                     o_done, o_grant, o_rdata, o_rw, o_wr_paddr, o_wr_data);
        end
        penable      = 1'b0;
        pready       = 1'b0;
        req_valid[1] = 1'b0;
        tick();
        n_checks++;
        if (o_done !== 4'b0000 || o_grant !== 4'b0000) begin
            n_errors++;
            $display("FAIL wr_release: got d=%b g=%b want 0000/0000", o_done, o_grant);
        end
    endtask

    task automatic test_read_wait();
        bit ok;
        set_req(0, 1'b0, 8'h10, 8'h99);
        wait_transfer(ok);
        n_checks++;
        if (!ok || {o_rd_paddr, o_wr_paddr, o_wr_data, o_rw} !== {8'h10, 8'h00, 8'h00, 1'b0}) begin
            n_errors++;
            $display("FAIL rd_issue: got ok=%b ra=%h wa=%h wd=%h rw=%b want 1/10/00/00/0",
                     ok, o_rd_paddr, o_wr_paddr, o_wr_data, o_rw);
        end
        apb_slave(2, 8'h5E);
        n_checks++;
        if ({o_done, o_rdata, o_rd_paddr} !== {4'b0001, 8'h5E, 8'h10}) begin
            n_errors++;
            $display("FAIL rd_done: got d=%b rd=%h ra=%h want 0001/5e/10", o_done, o_rdata, o_rd_paddr);
        end
        req_valid[0] = 1'b0;
        tick();
    endtask

    task automatic test_ptr_wrap();
        bit ok;
        logic [3:0] pat [3];
        logic [3:0] exp [3];
        pat[0] = 4'b1000; exp[0] = 4'b1000;
        pat[1] = 4'b0100; exp[1] = 4'b0100;
        pat[2] = 4'b0101; exp[2] = 4'b0001;
        for (int i = 0; i < 3; i++) begin
            for (int k = 0; k < 4; k++) if (pat[i][k]) set_req(k, 1'b1, 8'h20 + 8'(k), 8'h00);
            wait_transfer(ok);
            n_checks++;
            if (!ok || o_grant !== exp[i]) begin
                n_errors++;
                $display("FAIL wrap_grant_%0d: got ok=%b g=%b want 1/%b", i, ok, o_grant, exp[i]);
            end
            apb_slave(0, 8'h00);
            n_checks++;
            if (o_done !== exp[i]) begin
                n_errors++;
                $display("FAIL wrap_done_%0d: got %b want %b", i, o_done, exp[i]);
            end
            req_valid = 4'b0000;
            tick();
        end
    endtask

    task automatic test_watchdog();
        bit ok;
        set_req(0, 1'b0, 8'h55, 8'h00);
        wait_transfer(ok);
        tick();
        tick();
        penable = 1'b1;
        pready  = 1'b0;
        repeat (14) tick();
        n_checks++;
        if (!ok || o_err !== 1'b0 || o_state !== 2'd2) begin
            n_errors++;
            $display("FAIL wd_before: got ok=%b err=%b state=%0d want 1/0/2", ok, o_err, o_state);
        end
        tick();
        n_checks++;
        if (o_err !== 1'b1 || o_done !== 4'b0000) begin
            n_errors++;
            $display("FAIL wd_rise: got err=%b d=%b want 1/0000", o_err, o_done);
        end
        repeat (5) tick();
        pready   = 1'b1;
        rdata_in = 8'hC3;
        tick();
        n_checks++;
        if (o_done !== 4'b0001 || o_rdata !== 8'hC3 || o_err !== 1'b1) begin
            n_errors++;
            $display("FAIL wd_done: got d=%b rd=%h err=%b want 0001/c3/1", o_done, o_rdata, o_err);
        end
        penable      = 1'b0;
        pready       = 1'b0;
        req_valid[0] = 1'b0;
        tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        n_checks++;
        if (o_err !== 1'b0) begin
            n_errors++;
            $display("FAIL wd_clear: got %b want 0", o_err);
        end
        // Clear held across a fresh timeout: the set edge must win.
        set_req(0, 1'b0, 8'h56, 8'h00);
        wait_transfer(ok);
        err_clr = 1'b1;
        tick();
        tick();
        penable = 1'b1;
        repeat (15) tick();
        n_checks++;
        if (o_err !== 1'b1) begin
            n_errors++;
            $display("FAIL wd_set_wins: got %b want 1", o_err);
        end
        tick();
        n_checks++;
        if (o_err !== 1'b0) begin
            n_errors++;
            $display("FAIL wd_clr_after: got %b want 0", o_err);
        end
        pready = 1'b1;
        tick();
        err_clr      = 1'b0;
        penable      = 1'b0;
        pready       = 1'b0;
        req_valid[0] = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_wait();
        bit ok;
        set_req(1, 1'b1, 8'h22, 8'h33);
        wait_transfer(ok);
        set_req(2, 1'b1, 8'h44, 8'h66);
        tick();
        tick();
        penable = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (!ok || all_outs() !== 43'd0 || o_state !== 2'd0) begin
            n_errors++;
            $display("FAIL rst_async: got ok=%b outs=%h state=%0d want 1/0/0", ok, all_outs(), o_state);
        end
        tick();
        n_checks++;
        if (o_done !== 4'b0000 || o_transfer !== 1'b0) begin
            n_errors++;
            $display("FAIL rst_no_done: got d=%b t=%b want 0000/0", o_done, o_transfer);
        end
        penable = 1'b0;
        rst     = 1'b0;
        tick();
        n_checks++;
        if (o_transfer !== 1'b1 || o_grant !== 4'b0010 || o_wr_paddr !== 8'h22) begin
            n_errors++;
            $display("FAIL rst_regrant: got t=%b g=%b wa=%h want 1/0010/22", o_transfer, o_grant, o_wr_paddr);
        end
        apb_slave(0, 8'h00);
        n_checks++;
        if (o_done !== 4'b0010) begin
            n_errors++;
            $display("FAIL rst_done1: got %b want 0010", o_done);
        end
        req_valid[1] = 1'b0;
        wait_transfer(ok);
        n_checks++;
        if (!ok || o_grant !== 4'b0100) begin
            n_errors++;
            $display("FAIL rst_next: got ok=%b g=%b want 1/0100", ok, o_grant);
        end
        apb_slave(0, 8'h00);
        req_valid[2] = 1'b0;
        tick();
    endtask

    initial begin
        req_valid = '0;
        req_write = '0;
        req_addr  = '0;
        req_wdata = '0;
        penable   = 1'b0;
        pready    = 1'b0;
        rdata_in  = '0;
        err_clr   = 1'b0;
        rst       = 1'b1;
        test_reset();
        test_rr_fairness();
        test_single_write();
        test_read_wait();
        test_ptr_wrap();
        test_watchdog();
        test_reset_mid_wait();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
